// File: rtl/alarm_mode_controller.sv
// rtl/alarm_mode_controller.sv - alarm clock mode FSM, button arbitration, adjust strobes and buzzer
// Optional snooze support is enabled by defining SNOOZE_EN.
module alarm_mode_controller #(
    parameter int IDLE_SECS   = 10,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       sec_tick,
    input  logic       time_match,
    output logic [1:0] mode,
    output logic       field_sel,
    output logic       inc_time,
    output logic       dec_time,
    output logic       inc_alarm,
    output logic       dec_alarm,
    output logic       alarm_en,
    output logic       buzzer
);
    localparam int MAX_AB = (IDLE_SECS > RING_SECS) ? IDLE_SECS : RING_SECS;
    localparam int MAXP   = (MAX_AB > SNOOZE_SECS) ? MAX_AB : SNOOZE_SECS;
    localparam int CW     = $clog2(MAXP + 1);

    typedef enum logic [1:0] {
        CLOCK     = 2'b00,
        SET_TIME  = 2'b01,
        SET_ALARM = 2'b10,
        RINGING   = 2'b11
    } state_t;

    state_t        state;
    logic          match_q;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] ring_cnt;
`ifdef SNOOZE_EN
    logic          snooze_act;
    logic [CW-1:0] snooze_cnt;
`endif

    logic p_c, p_u, p_d, p_lr, any_press, match_rise;

    // Fixed priority C > U > D > L > R; L and R share the same action.
    always_comb begin
        p_c        = btn_c;
        p_u        = btn_u & ~btn_c;
        p_d        = btn_d & ~btn_c & ~btn_u;
        p_lr       = (btn_l | btn_r) & ~btn_c & ~btn_u & ~btn_d;
        any_press  = btn_c | btn_u | btn_d | btn_l | btn_r;
        match_rise = time_match & ~match_q;
    end

    assign mode = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLOCK;
            match_q   <= 1'b0;
            idle_cnt  <= '0;
            ring_cnt  <= '0;
            field_sel <= 1'b1;
            inc_time  <= 1'b0;
            dec_time  <= 1'b0;
            inc_alarm <= 1'b0;
            dec_alarm <= 1'b0;
            alarm_en  <= 1'b0;
            buzzer    <= 1'b0;
`ifdef SNOOZE_EN
            snooze_act <= 1'b0;
            snooze_cnt <= '0;
`endif
        end else begin
            match_q   <= time_match;
            inc_time  <= 1'b0;
            dec_time  <= 1'b0;
            inc_alarm <= 1'b0;
            dec_alarm <= 1'b0;
`ifdef SNOOZE_EN
            if (snooze_act && sec_tick && snooze_cnt != '1)
                snooze_cnt <= snooze_cnt + CW'(1);
`endif
            case (state)
                CLOCK: begin
                    if (match_rise && alarm_en) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                        buzzer   <= 1'b1;
`ifdef SNOOZE_EN
                        snooze_act <= 1'b0;
                    end else if (snooze_act && sec_tick && alarm_en &&
                                 snooze_cnt >= CW'(SNOOZE_SECS - 1)) begin
                        state      <= RINGING;
                        ring_cnt   <= '0;
                        buzzer     <= 1'b1;
                        snooze_act <= 1'b0;
`endif
                    end else if (p_c) begin
                        state     <= SET_TIME;
                        field_sel <= 1'b1;
                        idle_cnt  <= '0;
`ifdef SNOOZE_EN
                        snooze_act <= 1'b0;
`endif
                    end else if (p_u) begin
                        alarm_en <= ~alarm_en;
`ifdef SNOOZE_EN
                        if (alarm_en)
                            snooze_act <= 1'b0;
`endif
                    end
                end
                SET_TIME, SET_ALARM: begin
                    if (any_press) begin
                        idle_cnt <= '0;
                        if (p_c) begin
                            state     <= (state == SET_TIME) ? SET_ALARM : CLOCK;
                            field_sel <= (state == SET_TIME) ? 1'b1 : field_sel;
                        end else if (p_u) begin
                            inc_time  <= (state == SET_TIME);
                            inc_alarm <= (state == SET_ALARM);
                        end else if (p_d) begin
                            dec_time  <= (state == SET_TIME);
                            dec_alarm <= (state == SET_ALARM);
                        end else if (p_lr) begin
                            field_sel <= ~field_sel;
                        end
                    end else if (sec_tick) begin
                        if (idle_cnt >= CW'(IDLE_SECS - 1)) begin
                            state    <= CLOCK;
                            idle_cnt <= '0;
                        end else if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + CW'(1);
                        end
                    end
                end
                RINGING: begin
                    if (any_press) begin
                        state  <= CLOCK;
                        buzzer <= 1'b0;
`ifdef SNOOZE_EN
                        snooze_act <= p_c;
                        snooze_cnt <= '0;
`endif
                    end else if (sec_tick) begin
                        if (ring_cnt >= CW'(RING_SECS - 1)) begin
                            state  <= CLOCK;
                            buzzer <= 1'b0;
`ifdef SNOOZE_EN
                            snooze_act <= 1'b0;
`endif
                        end else if (ring_cnt != '1) begin
                            ring_cnt <= ring_cnt + CW'(1);
                        end
                    end
                end
                default: state <= CLOCK;
            endcase
        end
    end
endmodule

// File: doc/alarm_mode_controller.md
Name: alarm_mode_controller

Overview:
Central user-interface sequencer for the alarm clock. It consumes the single-cycle press pulses produced by the per-button pushbutton detectors and arbitrates between them. It runs the clock/set-time/set-alarm/ringing mode FSM and emits one-cycle adjust strobes to the time and alarm counters. It also drives the alarm-enable flag and the buzzer.

Parameters:
IDLE_SECS, 10, sec_tick count with no press in SET_TIME/SET_ALARM before auto-return to CLOCK
RING_SECS, 60, sec_tick count in RINGING before auto-dismiss
SNOOZE_SECS, 300, snooze interval in sec_ticks; used only with SNOOZE_EN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_c  in  1  centre-button press pulse, 1 cycle wide
btn_u  in  1  up-button press pulse
btn_d  in  1  down-button press pulse
btn_l  in  1  left-button press pulse
btn_r  in  1  right-button press pulse
sec_tick  in  1  one-cycle strobe once per second
time_match  in  1  level: current time equals alarm time
mode  out  2  00 CLOCK, 01 SET_TIME, 10 SET_ALARM, 11 RINGING
field_sel  out  1  1 = hours, 0 = minutes
inc_time, dec_time  out  1 each  one-cycle adjust strobes for the time counter
inc_alarm, dec_alarm  out  1 each  one-cycle adjust strobes for the alarm register
alarm_en  out  1  alarm armed
buzzer  out  1  high while RINGING

Behaviour:
- Reset (reset=0, async): mode=CLOCK, field_sel=1, all strobes 0, alarm_en=0, buzzer=0, counters 0, match_q=0.
- All outputs are registered. A press in cycle N produces its mode change or strobe in cycle N+1. Strobes are exactly 1 cycle wide.
- Arbitration: only one press is accepted per cycle. Fixed priority is C > U > D > L > R. Lower-priority simultaneous presses are dropped, not queued.
- match_q registers time_match. match_rise = time_match & ~match_q.
- CLOCK:
  - C -> SET_TIME, with field_sel=1.
  - U toggles alarm_en.
  - D, L and R are ignored.
  - match_rise & alarm_en -> RINGING. This takes precedence over any press in the same cycle, and that press is dropped.
- SET_TIME:
  - U -> inc_time. D -> dec_time.
  - L or R toggles field_sel.
  - C -> SET_ALARM, with field_sel=1.
  - time_match is ignored.
- SET_ALARM: same as SET_TIME, but U/D drive inc_alarm/dec_alarm and C -> CLOCK.
- Idle timer (SET_TIME/SET_ALARM):
  - Cleared on every accepted press and on every state change.
  - Increments on sec_tick.
  - When the count reaches IDLE_SECS on a sec_tick -> CLOCK.
  - A press in the same cycle as the timeout wins: it is processed and the timer clears.
- RINGING:
  - buzzer=1.
  - Any press -> CLOCK (dismiss). alarm_en is unchanged.
  - Ring timer counts sec_ticks. At RING_SECS -> CLOCK.
  - A press and a timeout in the same cycle give the same result: CLOCK.
- Re-ring: RINGING is entered only on match_rise. After a dismiss inside the matching minute, time_match stays high and the alarm does not re-ring.
- Counter widths: $clog2(max param + 1). Counters saturate and never wrap.
- Reset asserted mid-operation returns everything to the reset state immediately. Any in-flight strobe is cut.

Optional Feature:
SNOOZE_EN
- Defined:
  - In RINGING, btn_c is a snooze: go to CLOCK, buzzer=0, start the snooze counter.
  - U/D/L/R in RINGING dismiss and cancel any snooze.
  - When the snooze counter reaches SNOOZE_SECS on a sec_tick, mode is CLOCK and alarm_en=1 -> RINGING, independent of time_match.
  - Clearing alarm_en or entering SET_TIME cancels the snooze.
  - The RING_SECS timeout also cancels the snooze.
- Undefined: no snooze logic. All presses in RINGING dismiss. SNOOZE_SECS is unused.

Test Plan:
- Bench parameters: IDLE_SECS=4, RING_SECS=3, SNOOZE_SECS=2; reset released at cycle 2.
- Reset: hold reset=0 with random buttons toggling -> mode=00, field_sel=1, alarm_en=0, buzzer=0, no strobes.
- Adjust path: from CLOCK, C, U, R, D, C, C -> mode sequence 01, 01, 01, 01, 10, 00. inc_time pulses once with field_sel=1, then dec_time pulses once with field_sel=0, each strobe 1 cycle, 1 cycle after its press.
- Arbitration: in SET_TIME, U+D+L asserted in the same cycle -> only inc_time fires; no dec_time; field_sel unchanged.
- Idle timeout: enter SET_ALARM with no presses -> mode=00 on the 4th sec_tick. A U on the 3rd tick restarts the count, so a further 4 ticks are needed.
- Alarm: alarm_en=1 (U in CLOCK), raise time_match -> mode=11, buzzer=1 the next cycle. 3 sec_ticks -> mode=00, buzzer=0. Holding time_match high afterwards gives no re-ring. Drop and re-raise time_match -> rings again.
- Simultaneous and snooze:
  - time_match rise and btn_c in the same cycle in CLOCK -> RINGING, with no SET_TIME entry.
  - With SNOOZE_EN defined: C in RINGING -> mode=00, then RINGING again after 2 sec_ticks.
  - With SNOOZE_EN defined: L in RINGING -> no return.
